// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - FSM state encoding and ALU select codes shared by the ALU share arbiter
package alu_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'b00;
    localparam state_t ST_EXEC = 2'b01;
    localparam state_t ST_RESP = 2'b10;

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_SLT = 3'b111;

    function automatic logic sel_supported(input logic [2:0] sel);
        return sel inside {SEL_AND, SEL_OR, SEL_ADD, SEL_SUB, SEL_SLT};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with one-hot grant and last-grant register
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Last-grant starts at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (|grant) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one combinational ALU between two requesters; ALU_ARB_OPCHK_EN enables reserved-opcode error responses
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    input  logic             REQ1_VALID,
    output logic             REQ0_READY,
    output logic             REQ1_READY,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    input  logic [2:0]       REQ0_SELECT,
    input  logic [2:0]       REQ1_SELECT,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [2:0]       ALU_SELECT,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_ZERO,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic [WIDTH-1:0] RSP_OUT,
    output logic             RSP_ZERO,
    output logic             RSP_ERR
);

    import alu_arb_pkg::*;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       sel_q;
    logic             id_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic [1:0]       grant;
    logic             in_idle;
    logic             in_exec;
    logic             in_resp;
    logic             bad_op;
    logic             drive_alu;

    // Every output is forced quiet while reset is held, whatever the state register says.
    assign in_idle = (state == ST_IDLE) && !RST;
    assign in_exec = (state == ST_EXEC) && !RST;
    assign in_resp = (state == ST_RESP) && !RST;

`ifdef ALU_ARB_OPCHK_EN
    logic err_q;

    assign bad_op  = !sel_supported(sel_q);
    assign RSP_ERR = in_resp & err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (state == ST_EXEC) begin
            err_q <= bad_op;
        end
    end
`else
    assign bad_op  = 1'b0;
    assign RSP_ERR = 1'b0;
`endif

    rr_arb2 u_rr_arb2 (
        .clk    (CLK),
        .rst    (RST),
        .req    ({REQ1_VALID, REQ0_VALID}),
        .enable (in_idle),
        .grant  (grant)
    );

    assign REQ0_READY = grant[0];
    assign REQ1_READY = grant[1];

    assign drive_alu  = in_exec & !bad_op;
    assign ALU_A      = drive_alu ? a_q   : '0;
    assign ALU_B      = drive_alu ? b_q   : '0;
    assign ALU_SELECT = drive_alu ? sel_q : 3'b000;

    assign RSP_VALID  = in_resp;
    assign RSP_ID     = in_resp & id_q;
    assign RSP_OUT    = in_resp ? res_q : '0;
    assign RSP_ZERO   = in_resp & zero_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            sel_q  <= 3'b000;
            id_q   <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        a_q   <= grant[1] ? REQ1_A      : REQ0_A;
                        b_q   <= grant[1] ? REQ1_B      : REQ0_B;
                        sel_q <= grant[1] ? REQ1_SELECT : REQ0_SELECT;
                        id_q  <= grant[1];
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_q  <= bad_op ? '0 : ALU_OUT;
                    zero_q <= !bad_op & ALU_ZERO;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed and randomized self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         REQ0_VALID = 1'b0;
    logic         REQ1_VALID = 1'b0;
    logic         REQ0_READY;
    logic         REQ1_READY;
    logic [W-1:0] REQ0_A = '0;
    logic [W-1:0] REQ0_B = '0;
    logic [W-1:0] REQ1_A = '0;
    logic [W-1:0] REQ1_B = '0;
    logic [2:0]   REQ0_SELECT = 3'b000;
    logic [2:0]   REQ1_SELECT = 3'b000;
    logic [W-1:0] ALU_A;
    logic [W-1:0] ALU_B;
    logic [2:0]   ALU_SELECT;
    logic [W-1:0] ALU_OUT;
    logic         ALU_ZERO;
    logic         RSP_VALID;
    logic         RSP_READY = 1'b0;
    logic         RSP_ID;
    logic [W-1:0] RSP_OUT;
    logic         RSP_ZERO;
    logic         RSP_ERR;

    alu_share_arbiter #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
        .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
        .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ0_SELECT(REQ0_SELECT), .REQ1_SELECT(REQ1_SELECT),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_SELECT(ALU_SELECT),
        .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_OUT(RSP_OUT), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR)
    );

    always #5 CLK = ~CLK;

    // Shared ALU; reserved codes return A^B so forwarding of them is visible.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] sel);
        case (sel)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic reserved_sel(input logic [2:0] sel);
`ifdef ALU_ARB_OPCHK_EN
        return sel inside {3'b011, 3'b100, 3'b101};
`else
        return 1'b0;
`endif
    endfunction

    assign ALU_OUT  = alu_fn(ALU_A, ALU_B, ALU_SELECT);
    assign ALU_ZERO = (ALU_OUT == '0);

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int grants[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level reference: m_age is cycles elapsed since the op was accepted (-1 = none in flight).
    int           m_age = -1;
    int           m_last = 1;
    logic [W-1:0] m_a, m_b, e_a, e_b, e_out;
    logic [2:0]   m_sel, e_sel;
    logic         m_id, e_r0, e_r1, e_valid, e_bad;

    always @(negedge CLK) begin
        if (REQ0_READY) grants.push_back(0);
        if (REQ1_READY) grants.push_back(1);
        e_r0 = 1'b0; e_r1 = 1'b0; e_valid = 1'b0;
        e_a = '0; e_b = '0; e_sel = 3'b000;
        e_bad = reserved_sel(m_sel);
        e_out = e_bad ? '0 : alu_fn(m_a, m_b, m_sel);
        if (!RST) begin
            if (m_age < 0) begin
                if (REQ0_VALID && REQ1_VALID) begin
                    e_r0 = (m_last == 1);
                    e_r1 = (m_last == 0);
                end else begin
                    e_r0 = REQ0_VALID;
                    e_r1 = REQ1_VALID;
                end
            end else if (m_age == 1) begin
                if (!e_bad) begin
                    e_a = m_a; e_b = m_b; e_sel = m_sel;
                end
            end else begin
                e_valid = 1'b1;
            end
        end
        chk("m_ready0", REQ0_READY, e_r0);
        chk("m_ready1", REQ1_READY, e_r1);
        chk("m_alu_a", ALU_A, e_a);
        chk("m_alu_b", ALU_B, e_b);
        chk("m_alu_sel", ALU_SELECT, e_sel);
        chk("m_rsp_valid", RSP_VALID, e_valid);
        if (e_valid) begin
            chk("m_rsp_id", RSP_ID, m_id);
            chk("m_rsp_out", RSP_OUT, e_out);
            chk("m_rsp_zero", RSP_ZERO, !e_bad && (e_out == '0));
            chk("m_rsp_err", RSP_ERR, e_bad);
        end
        if (RST) begin
            m_age = -1;
            m_last = 1;
        end else if (m_age < 0) begin
            if (e_r0 || e_r1) begin
                m_id   = e_r1;
                m_a    = e_r1 ? REQ1_A : REQ0_A;
                m_b    = e_r1 ? REQ1_B : REQ0_B;
                m_sel  = e_r1 ? REQ1_SELECT : REQ0_SELECT;
                m_last = e_r1 ? 1 : 0;
                m_age  = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (RSP_READY) begin
            m_age = -1;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(input int who, output int at);
        at = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if ((who == 0 && REQ0_READY) || (who == 1 && REQ1_READY)) begin
                at = cyc;
                return;
            end
        end
        chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_rsp(output int at);
        at = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                at = cyc;
                return;
            end
        end
        chk("rsp_timeout", 0, 1);
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 30 && grants.size() < n; i++) @(negedge CLK);
        if (grants.size() < n) begin
            chk("grant_timeout", grants.size(), n);
            while (grants.size() < n) grants.push_back(-1);
        end
    endtask

    task automatic rnd_op(output logic [W-1:0] a, output logic [W-1:0] b, output logic [2:0] sel);
        a   = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : W'($urandom);
        b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 15)) : W'($urandom));
        sel = 3'($urandom_range(0, 7));
    endtask

    initial begin
        int n, m;
        bit acc0, acc1;

        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        bit acc0, acc1;

        repeat (3) @(negedge CLK);
        chk("rst_ready0", REQ0_READY, 0);
        chk("rst_ready1", REQ1_READY, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_id", RSP_ID, 0);
        chk("rst_rsp_out", RSP_OUT, 0);
        chk("rst_rsp_zero", RSP_ZERO, 0);
        chk("rst_rsp_err", RSP_ERR, 0);
        chk("rst_alu_sel", ALU_SELECT, 0);
        step();
        RST = 1'b0;

        // ADD 5+3 from requester 0, two-cycle latency
        REQ0_A = 5; REQ0_B = 3; REQ0_SELECT = 3'b010; REQ0_VALID = 1'b1; RSP_READY = 1'b1;
        wait_ready(0, n);
        step();
        REQ0_VALID = 1'b0;
        wait_rsp(m);
        chk("add_latency", m - n, 2);
        chk("add_out", RSP_OUT, 8);
        chk("add_zero", RSP_ZERO, 0);
        chk("add_id", RSP_ID, 0);
        step();

        // SUB 7-7 from requester 1 with response back-pressure; requester 0 waits
        REQ1_A = 7; REQ1_B = 7; REQ1_SELECT = 3'b110; REQ1_VALID = 1'b1; RSP_READY = 1'b0;
        wait_ready(1, n);
        step();
        REQ1_VALID = 1'b0;
        REQ0_A = 32'hF0; REQ0_B = 32'h0F; REQ0_SELECT = 3'b000; REQ0_VALID = 1'b1;
        wait_rsp(m);
        chk("sub_latency", m - n, 2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            chk("hold_valid", RSP_VALID, 1);
            chk("hold_out", RSP_OUT, 0);
            chk("hold_zero", RSP_ZERO, 1);
            chk("hold_id", RSP_ID, 1);
            chk("hold_no_ready0", REQ0_READY, 0);
        end
        step();
        RSP_READY = 1'b1;
        @(negedge CLK);
        chk("hs_cycle_valid", RSP_VALID, 1);
        chk("hs_cycle_no_ready0", REQ0_READY, 0);
        @(negedge CLK);
        chk("after_hs_ready0", REQ0_READY, 1);
        step();
        REQ0_VALID = 1'b0;
        wait_rsp(m);
        chk("and_out", RSP_OUT, 0);
        chk("and_zero", RSP_ZERO, 1);
        chk("and_id", RSP_ID, 0);
        step();

        // SLT 2<9
        REQ1_A = 2; REQ1_B = 9; REQ1_SELECT = 3'b111; REQ1_VALID = 1'b1;
        wait_ready(1, n);
        step();
        REQ1_VALID = 1'b0;
        wait_rsp(m);
        chk("slt_out", RSP_OUT, 1);
        chk("slt_id", RSP_ID, 1);
        step();

        // Continuous contention after reset alternates starting with 0
        RST = 1'b1;
        step();
        RST = 1'b0;
        grants.delete();
        REQ0_A = 1; REQ0_B = 1; REQ0_SELECT = 3'b010; REQ0_VALID = 1'b1;
        REQ1_A = 6; REQ1_B = 9; REQ1_SELECT = 3'b001; REQ1_VALID = 1'b1;
        wait_grants(4);
        chk("rr_g0", grants[0], 0);
        chk("rr_g1", grants[1], 1);
        chk("rr_g2", grants[2], 0);
        chk("rr_g3", grants[3], 1);
        step();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (4) step();

        // Reset during EXEC drops the op and restores requester-0 tie priority
        REQ0_A = 4; REQ0_B = 4; REQ0_SELECT = 3'b010; REQ0_VALID = 1'b1;
        wait_ready(0, n);
        step();
        REQ0_VALID = 1'b0;
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("rst_exec_no_rsp", RSP_VALID, 0);
        end
        step();
        grants.delete();
        REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
        wait_grants(1);
        chk("rst_exec_tie", grants[0], 0);
        step();
        REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
        repeat (4) step();

        // Reserved select code 100
        REQ0_A = 3; REQ0_B = 6; REQ0_SELECT = 3'b100; REQ0_VALID = 1'b1;
        wait_ready(0, n);
        step();
        REQ0_VALID = 1'b0;
        @(negedge CLK);
`ifdef ALU_ARB_OPCHK_EN
        chk("opchk_alu_sel", ALU_SELECT, 0);
        chk("opchk_alu_a", ALU_A, 0);
`else
        chk("opchk_alu_sel", ALU_SELECT, 4);
        chk("opchk_alu_a", ALU_A, 3);
`endif
        wait_rsp(m);
        chk("opchk_latency", m - n, 2);
`ifdef ALU_ARB_OPCHK_EN
        chk("opchk_err", RSP_ERR, 1);
        chk("opchk_out", RSP_OUT, 0);
`else
        chk("opchk_err", RSP_ERR, 0);
        chk("opchk_out", RSP_OUT, 5);
`endif
        chk("opchk_zero", RSP_ZERO, 0);
        step();

        // Randomized traffic, back-pressure and occasional reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            acc0 = REQ0_READY;
            acc1 = REQ1_READY;
            step();
            if (acc0 || !REQ0_VALID) begin
                REQ0_VALID = ($urandom_range(0, 2) == 0);
                rnd_op(REQ0_A, REQ0_B, REQ0_SELECT);
            end
            if (acc1 || !REQ1_VALID) begin
                REQ1_VALID = ($urandom_range(0, 2) == 0);
                rnd_op(REQ1_A, REQ1_B, REQ1_SELECT);
            end
            RSP_READY = ($urandom_range(0, 3) != 0);
            RST = ($urandom_range(0, 199) == 0);
        end

        RST = 1'b0; REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; RSP_READY = 1'b1;
        repeat (6) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: REQ0_VALID / REQ1_VALID  input  1  requester n has an operation pending.
REQ-005 SHALL have ports: REQ0_READY / REQ1_READY  output  1  operation of requester n accepted this cycle.
REQ-006 SHALL have ports: REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  WIDTH  operands.
REQ-007 SHALL have ports: REQ0_SELECT / REQ1_SELECT  input  3  ALU operation code (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
REQ-008 SHALL have ports: ALU_A, ALU_B  output  WIDTH; ALU_SELECT  output  3  drive the shared ALU.
REQ-009 SHALL have ports: ALU_OUT  input  WIDTH; ALU_ZERO  input  1  combinational ALU result.
REQ-010 SHALL have ports: RSP_VALID  output  1; RSP_READY  input  1; RSP_ID  output  1 (owning requester); RSP_OUT  output  WIDTH; RSP_ZERO  output  1; RSP_ERR  output  1.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-012 In IDLE, SHALL grant one valid requester, assert only its REQn_READY combinationally, latch its A/B/SELECT and ID, move to EXEC.
REQ-013 SHALL resolve simultaneous REQ0_VALID and REQ1_VALID round-robin: grant requester not granted last; single valid requester always wins.
REQ-014 SHALL keep REQn_READY low in EXEC and RESP; requesters hold operands stable while VALID high and READY low.
REQ-015 In EXEC, SHALL drive latched operands on ALU_A/ALU_B/ALU_SELECT, register ALU_OUT/ALU_ZERO at cycle end, move to RESP.
REQ-016 Outside EXEC, SHALL drive ALU_A, ALU_B, ALU_SELECT to zero.
REQ-017 In RESP, SHALL hold RSP_VALID high with stable RSP_ID/OUT/ZERO/ERR until RSP_READY high; on that cycle return to IDLE.
REQ-018 Latency: acceptance at cycle N yields RSP_VALID at N+2; throughput max one op per 3 cycles with RSP_READY tied high.
REQ-019 SHALL not accept a new request in the cycle RSP handshake completes (next accept earliest one cycle later in IDLE).
REQ-020 Result width SHALL equal WIDTH; no sign/carry outputs beyond ALU_ZERO.

Reset
REQ-021 On RST high at clock edge, SHALL enter IDLE, clear latched operands/result, set last-grant to requester 1 (requester 0 wins first tie).
REQ-022 During/after reset: REQn_READY=0 while RST high, RSP_VALID=0, RSP_ID=0, RSP_OUT=0, RSP_ZERO=0, RSP_ERR=0, ALU_* =0.
REQ-023 Reset in EXEC or RESP SHALL discard in-flight operation without response.

Configuration
REQ-024 Macro ALU_ARB_OPCHK_EN defined: SELECT codes 011, 100, 101 SHALL be accepted, skip ALU drive in EXEC (ALU_* stay zero), respond RSP_ERR=1, RSP_OUT=0, RSP_ZERO=0, same latency.
REQ-025 Macro undefined: no code check, RSP_ERR SHALL be tied 0, all codes forwarded to ALU.

Structure
REQ-026 Shared package alu_arb_pkg SHALL hold FSM state typedef and ALU SELECT code constants (AND, OR, ADD, SUB, SLT).
REQ-027 Round-robin grant logic SHALL be sub-module rr_arb2 (two requests, last-grant register, one-hot grant).

Verification
REQ-028 Reset then REQ0 only, A=5,B=3,SELECT=010 -> READY0 at cycle N, RSP_VALID at N+2, RSP_OUT=8, RSP_ZERO=0, RSP_ID=0.
REQ-029 Both valid continuously, RSP_READY=1 -> grants alternate 0,1,0,1; first after reset is 0.
REQ-030 REQ1 A=7,B=7,SELECT=110, RSP_READY low 5 cycles -> RSP_VALID held, RSP_OUT=0, RSP_ZERO=1 stable; no new READY until handshake.
REQ-031 SLT A=2,B=9 -> RSP_OUT=1; AND 0xF0,0x0F -> RSP_OUT=0, RSP_ZERO=1.
REQ-032 RST asserted in EXEC -> next cycle IDLE, RSP_VALID never asserted for that op, next tie granted to 0.
REQ-033 With ALU_ARB_OPCHK_EN, SELECT=100 -> RSP_ERR=1, RSP_OUT=0, ALU_SELECT stays 000; without macro -> RSP_ERR=0.
